// File: rtl/line_window_fetcher.sv
// line_window_fetcher: fetches four 9-cell line windows around a move from board memory
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, x, y, player        request pulse with move coordinate and side to evaluate
//   rd_en, rd_addr, rd_data    board read port, data one cycle after rd_en
//   win_valid, win_ready       window handshake
//   win_dir, win_my, win_opp   window direction and my/opponent bitmaps
//   busy, done                 activity flag and completion pulse
module line_window_fetcher #(
  parameter int BOARD_SIZE = 15,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        x,
  input  logic [3:0]        y,
  input  logic              player,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [1:0]        win_dir,
  output logic [8:0]        win_my,
  output logic [8:0]        win_opp,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, FETCH, TAIL, EMIT, DONE} state_t;
  localparam logic signed [5:0] BS = 6'(BOARD_SIZE);
  state_t state_q, state_d;
  logic [3:0] k_q, k_d, x_q, x_d, y_q, y_d, idx;
  logic [1:0] dir_q, dir_d, my_code, opp_code;
  logic player_q, player_d, pend_q, pend_d, on_board;
  logic [8:0] my_q, my_d, opp_q, opp_d;
  logic [ADDR_W-1:0] addr_q, addr_now;
  logic signed [5:0] xs, ys, off, cx, cy;
  assign xs = $signed({2'b00, x_q});
  assign ys = $signed({2'b00, y_q});
  assign off = $signed({2'b00, k_q}) - 6'sd4;
  assign cx = xs + ((dir_q != 2'd1) ? off : 6'sd0);
  assign cy = ys + ((dir_q == 2'd0) ? 6'sd0 : (dir_q == 2'd3) ? -off : off);
  // An out-of-range move makes the whole window off-board, not just the cells that overflow
  assign on_board = xs < BS && ys < BS && cx >= 6'sd0 && cx < BS && cy >= 6'sd0 && cy < BS;
  assign addr_now = ADDR_W'(cy[3:0]) * ADDR_W'(BOARD_SIZE) + ADDR_W'(cx[3:0]);
  assign my_code = player_q ? 2'b10 : 2'b01;
  assign opp_code = player_q ? 2'b01 : 2'b10;
  // k runs to 9 in TAIL so the returning cell is always k-1
  assign idx = k_q - 4'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      dir_q <= '0;
      x_q <= '0;
      y_q <= '0;
      player_q <= 1'b0;
      pend_q <= 1'b0;
      my_q <= '0;
      opp_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      dir_q <= dir_d;
      x_q <= x_d;
      y_q <= y_d;
      player_q <= player_d;
      pend_q <= pend_d;
      my_q <= my_d;
      opp_q <= opp_d;
      addr_q <= rd_addr;
    end
  end
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    dir_d = dir_q;
    x_d = x_q;
    y_d = y_q;
    player_d = player_q;
    my_d = my_q;
    opp_d = opp_q;
    pend_d = rd_en;
    // pend_q marks that the previous cell was really read, so skipped cells load 0
    if ((state_q == FETCH && k_q != 4'd0) || state_q == TAIL) begin
      my_d[idx] = pend_q && rd_data == my_code;
      opp_d[idx] = pend_q && rd_data == opp_code;
    end
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        k_d = '0;
        dir_d = '0;
        x_d = x;
        y_d = y;
        player_d = player;
      end
      FETCH: begin
        k_d = k_q + 4'd1;
        state_d = (k_q == 4'd8) ? TAIL : FETCH;
      end
      TAIL: state_d = EMIT;
      EMIT: if (win_ready) begin
        state_d = (dir_q == 2'd3) ? DONE : FETCH;
        dir_d = dir_q + 2'd1;
        k_d = '0;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rd_en = state_q == FETCH && on_board;
    rd_addr = rd_en ? addr_now : addr_q;
    win_valid = state_q == EMIT;
    busy = state_q == FETCH || state_q == TAIL || state_q == EMIT;
    done = state_q == DONE;
    win_dir = dir_q;
    win_my = my_q;
    win_opp = opp_q;
  end
endmodule
